// File: rtl/prog_serial_encoder_if.sv
// Program-number link handshake bundle between the word source (master) and the serial encoder (slave).
interface prog_serial_encoder_if #(
  parameter int PROG_NUM_SIZE = 6
);
  logic [PROG_NUM_SIZE-1:0] progNum;
  logic                     progValid;
  logic                     progReady;
  logic                     progOut;
  logic                     busy;

  modport master (
    output progNum,
    output progValid,
    input  progReady,
    input  progOut,
    input  busy
  );

  modport slave (
    input  progNum,
    input  progValid,
    output progReady,
    output progOut,
    output busy
  );
endinterface

// File: rtl/prog_serial_encoder.sv
// Serial transmitter for the program-number link: start bit, data LSB first, stop bit, all from flops.
// Define PROG_TX_PARITY_EN to insert an even-parity bit between the MSB and the stop bit.
module prog_serial_encoder #(
  parameter int PROG_NUM_SIZE = 6,
  parameter int CLKS_PER_BIT  = 16,
  parameter int BIT_CNT_SIZE  = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  prog_serial_encoder_if.slave progBus
);
  // state  | meaning
  // IDLE   | line high, ready to accept a word
  // START  | start bit, line low
  // DATA   | data bits, LSB first
  // PARITY | even parity bit (PROG_TX_PARITY_EN builds only)
  // STOP   | stop bit, line high
`ifdef PROG_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam int IDX_SIZE = (PROG_NUM_SIZE > 1) ? $clog2(PROG_NUM_SIZE) : 1;
  localparam logic [BIT_CNT_SIZE-1:0] LAST_CLK = BIT_CNT_SIZE'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_SIZE-1:0] ONE_CLK  = BIT_CNT_SIZE'(1);
  localparam logic [IDX_SIZE-1:0]     LAST_IDX = IDX_SIZE'(PROG_NUM_SIZE - 1);
  localparam logic [IDX_SIZE-1:0]     ONE_IDX  = IDX_SIZE'(1);

  state_t                   state;
  logic [PROG_NUM_SIZE-1:0] shiftReg;
  logic [BIT_CNT_SIZE-1:0]  bitCnt;
  logic [IDX_SIZE-1:0]      dataIdx;
  logic                     lineReg;
  logic                     readyReg;
  logic                     bitEnd;
`ifdef PROG_TX_PARITY_EN
  logic                     parityBit;
`endif

  assign bitEnd            = (bitCnt == LAST_CLK);
  assign progBus.progOut   = lineReg;
  assign progBus.progReady = readyReg;
  assign progBus.busy      = ~readyReg;

  // lineReg follows the state one edge late, so the start bit appears on the edge after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitCnt   <= '0;
      dataIdx  <= '0;
      lineReg  <= 1'b1;
      readyReg <= 1'b1;
`ifdef PROG_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      if (state == IDLE || bitEnd) begin
        bitCnt <= '0;
      end else begin
        bitCnt <= bitCnt + ONE_CLK;
      end

      case (state)
        IDLE: begin
          lineReg <= 1'b1;
          if (progBus.progValid) begin
            shiftReg <= progBus.progNum;
            dataIdx  <= '0;
            readyReg <= 1'b0;
            state    <= START;
`ifdef PROG_TX_PARITY_EN
            parityBit <= ^progBus.progNum;
`endif
          end
        end
        START: begin
          lineReg <= 1'b0;
          if (bitEnd) begin
            state <= DATA;
          end
        end
        DATA: begin
          lineReg <= shiftReg[0];
          if (bitEnd) begin
            shiftReg <= shiftReg >> 1;
            if (dataIdx == LAST_IDX) begin
              dataIdx <= '0;
`ifdef PROG_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              dataIdx <= dataIdx + ONE_IDX;
            end
          end
        end
`ifdef PROG_TX_PARITY_EN
        PARITY: begin
          lineReg <= parityBit;
          if (bitEnd) begin
            state <= STOP;
          end
        end
`endif
        STOP: begin
          lineReg <= 1'b1;
          if (bitEnd) begin
            readyReg <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          lineReg  <= 1'b1;
          readyReg <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prog_serial_encoder.sv
// Directed self-checking bench for prog_serial_encoder at CLKS_PER_BIT=4.
module tb_prog_serial_encoder;
  localparam int NS    = 6;
  localparam int CPB   = 4;
`ifdef PROG_TX_PARITY_EN
  localparam int NBITS = NS + 3;
`else
  localparam int NBITS = NS + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  prog_serial_encoder_if #(.PROG_NUM_SIZE(NS)) bus ();

  prog_serial_encoder #(
    .PROG_NUM_SIZE(NS),
    .CLKS_PER_BIT (CPB),
    .BIT_CNT_SIZE (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .progBus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line level i samples after the accept edge (sample 0 is the first start-bit cycle).
  function automatic logic expLine(input logic [NS-1:0] w, input int i);
    int lvl;
    lvl = i / CPB;
    if (lvl == 0) return 1'b0;
    if (lvl <= NS) return w[lvl-1];
`ifdef PROG_TX_PARITY_EN
    if (lvl == NS + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    bus.progValid = 1'b0;
    bus.progNum = '0;
    repeat (3) tick;
    vecs++;
    if ({bus.progOut, bus.progReady, bus.busy} !== 3'b110) begin
      errs++;
      $display("FAIL reset_hold: out/ready/busy=%b expected 110", {bus.progOut, bus.progReady, bus.busy});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick;
      vecs++;
      if ({bus.progOut, bus.progReady, bus.busy} !== 3'b110) begin
        errs++;
        $display("FAIL reset_idle[%0d]: out/ready/busy=%b expected 110", i, {bus.progOut, bus.progReady, bus.busy});
      end
    end
  endtask

  task automatic test_single_frame(input logic [NS-1:0] w);
    int lowCnt;
    bus.progNum = w;
    bus.progValid = 1'b1;
    tick;
    bus.progValid = 1'b0;
    vecs++;
    if ({bus.progOut, bus.progReady, bus.busy} !== 3'b101) begin
      errs++;
      $display("FAIL accept_edge w=%b: out/ready/busy=%b expected 101", w, {bus.progOut, bus.progReady, bus.busy});
    end
    lowCnt = (bus.progReady == 1'b0) ? 1 : 0;
    for (int i = 0; i < FRAME; i++) begin
      tick;
      if (bus.progReady == 1'b0) lowCnt++;
      vecs++;
      if (bus.progOut !== expLine(w, i)) begin
        errs++;
        $display("FAIL frame_line w=%b sample %0d: got %b expected %b", w, i, bus.progOut, expLine(w, i));
      end
    end
    vecs++;
    if (lowCnt != FRAME) begin
      errs++;
      $display("FAIL ready_low_len w=%b: got %0d cycles expected %0d", w, lowCnt, FRAME);
    end
    vecs++;
    if ({bus.progReady, bus.busy} !== 2'b10) begin
      errs++;
      $display("FAIL frame_end w=%b: ready/busy=%b expected 10", w, {bus.progReady, bus.busy});
    end
    repeat (3) tick;
  endtask

`ifdef PROG_TX_PARITY_EN
  task automatic test_parity;
    logic [NS-1:0] w;
    w = 6'b000111;
    bus.progNum = w;
    bus.progValid = 1'b1;
    tick;
    bus.progValid = 1'b0;
    repeat ((NS + 1) * CPB) tick;
    for (int i = 0; i < CPB; i++) begin
      tick;
      vecs++;
      if (bus.progOut !== 1'b1) begin
        errs++;
        $display("FAIL parity_000111 cycle %0d: got %b expected 1", i, bus.progOut);
      end
    end
    repeat (CPB + 3) tick;
    test_single_frame(6'b101101);
  endtask
`endif

  task automatic test_back_to_back;
    bus.progNum = 6'h3F;
    bus.progValid = 1'b1;
    tick;
    bus.progNum = 6'h00;
    for (int i = 0; i < FRAME + 1; i++) begin
      tick;
      if (i < FRAME) begin
        vecs++;
        if (bus.progOut !== expLine(6'h3F, i)) begin
          errs++;
          $display("FAIL b2b_first sample %0d: got %b expected %b", i, bus.progOut, expLine(6'h3F, i));
        end
      end
    end
    bus.progValid = 1'b0;
    vecs++;
    if ({bus.progOut, bus.progReady} !== 2'b10) begin
      errs++;
      $display("FAIL b2b_gap: out/ready=%b expected 10", {bus.progOut, bus.progReady});
    end
    for (int i = 0; i < FRAME; i++) begin
      tick;
      vecs++;
      if (bus.progOut !== expLine(6'h00, i)) begin
        errs++;
        $display("FAIL b2b_second sample %0d: got %b expected %b", i, bus.progOut, expLine(6'h00, i));
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      vecs++;
      if ({bus.progOut, bus.progReady} !== 2'b11) begin
        errs++;
        $display("FAIL b2b_idle %0d: out/ready=%b expected 11", i, {bus.progOut, bus.progReady});
      end
    end
  endtask

  task automatic test_mid_frame;
    logic [NS-1:0] w;
    logic expRdy;
    w = 6'b110010;
    bus.progNum = w;
    bus.progValid = 1'b1;
    tick;
    bus.progValid = 1'b0;
    for (int i = 0; i < FRAME + 8; i++) begin
      if (i == 10) begin
        bus.progNum = 6'b001101;
        bus.progValid = 1'b1;
      end
      if (i == 11) bus.progValid = 1'b0;
      tick;
      expRdy = (i >= FRAME - 1);
      vecs++;
      if ({bus.progOut, bus.progReady} !== {(i < FRAME) ? expLine(w, i) : 1'b1, expRdy}) begin
        errs++;
        $display("FAIL mid_frame sample %0d: out/ready=%b%b expected %b%b", i, bus.progOut, bus.progReady,
                 (i < FRAME) ? expLine(w, i) : 1'b1, expRdy);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [NS-1:0] w;
    w = 6'b111011;
    bus.progNum = w;
    bus.progValid = 1'b1;
    tick;
    bus.progValid = 1'b0;
    repeat (3 * CPB + 1) tick;
    vecs++;
    if (bus.progOut !== 1'b0) begin
      errs++;
      $display("FAIL pre_reset_bit2: got %b expected 0", bus.progOut);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.progOut, bus.progReady, bus.busy} !== 3'b110) begin
      errs++;
      $display("FAIL async_reset: out/ready/busy=%b expected 110", {bus.progOut, bus.progReady, bus.busy});
    end
    repeat (2) tick;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick;
      vecs++;
      if ({bus.progOut, bus.progReady, bus.busy} !== 3'b110) begin
        errs++;
        $display("FAIL post_reset_idle %0d: out/ready/busy=%b expected 110", i, {bus.progOut, bus.progReady, bus.busy});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_frame(6'b101101);
`ifdef PROG_TX_PARITY_EN
    test_parity;
`endif
    test_back_to_back;
    test_mid_frame;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/prog_serial_encoder.md
# prog_serial_encoder

Serial transmitter for the phase delay board's program-number link. Accepts a parallel `PROG_NUM_SIZE`-bit phase-delay program number and drives it onto the single-wire `progIn` serial line that the board's serial decoder samples. It runs in the controller/test fixture on the same `clk` domain and frames each word with start/stop bits at a fixed bit period.

## Interface
- `PROG_NUM_SIZE`, 6: width of the program number; matches the decoder.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; legal range ≥ 2.
- `BIT_CNT_SIZE`, 5: width of the bit-time counter; must be ≥ ceil(log2(`CLKS_PER_BIT`)).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `progNum` in `PROG_NUM_SIZE`: program number to send.
- `progValid` in 1: request to send `progNum`.
- `progReady` out 1: high when a new word can be accepted.
- `progOut` out 1: serial line, registered; idle high.
- `busy` out 1: high while a frame is on the line.

## Operation
- FSM states: IDLE, START, DATA, PARITY (exists only with the macro), STOP.
- IDLE: `progOut`=1, `progReady`=1, `busy`=0. A word is accepted on the edge where `progValid` && `progReady`. On that edge `progNum` is latched into a shift register, the bit-time counter is cleared, and the FSM moves to START.
- START: `progOut`=0 for one bit time, then DATA.
- DATA: sends `PROG_NUM_SIZE` bits, LSB first. Each bit is held one bit time; the shift register shifts right at each bit boundary. After the MSB the FSM moves to PARITY (if enabled) or STOP.
- STOP: `progOut`=1 for one bit time, then IDLE.
- `progReady` = (state==IDLE); `busy` = !`progReady`.
- Bit timing: the counter runs 0..`CLKS_PER_BIT`-1, and the bit boundary is at `CLKS_PER_BIT`-1. The counter wraps to 0 with no residue.
- `progValid` is ignored outside IDLE. Changes to `progNum` mid-frame have no effect on the word being sent.
- Reset asserted mid-frame: `progOut` goes to 1 immediately (async) and the FSM returns to IDLE. The partial frame is abandoned and nothing is resent.
- Reset values: `progOut`=1, `progReady`=1, `busy`=0, shift register 0, counters 0.

## Timing
- Latency: `progOut` falls on the first edge after the accept edge.
- Each line level is stable for exactly `CLKS_PER_BIT` cycles.
- Frame length: (`PROG_NUM_SIZE`+2)·`CLKS_PER_BIT` cycles without parity, (`PROG_NUM_SIZE`+3)·`CLKS_PER_BIT` with parity. Defaults give 128 or 144 cycles.
- `progReady` rises on the edge that ends STOP. With `progValid` held high, the next start bit begins one cycle later, so the minimum idle gap is 1 cycle beyond the stop bit.
- `progOut` is driven directly from a flop, with no combinational path from inputs.

## Configuration
- `PROG_TX_PARITY_EN` defined:
  - PARITY state inserted after the MSB.
  - `progOut` carries even parity, the XOR of the latched data bits, for one bit time.
- Not defined:
  - PARITY state and its logic are absent.
  - STOP follows the MSB directly.

## Test plan
- Reset idle: hold `rst_n`=0, then release with `progValid`=0 for 100 cycles. Expect `progOut`=1, `progReady`=1, `busy`=0 throughout.
- Single frame, `CLKS_PER_BIT`=4, `progNum`=6'b101101, no parity:
  - line sequence 0,1,0,1,1,0,1,1, each level 4 cycles;
  - `progReady` low for exactly 32 cycles.
- Parity enabled:
  - `progNum`=6'b000111: parity bit = 1, frame 36 cycles at `CLKS_PER_BIT`=4;
  - `progNum`=6'b101101: parity bit = 0.
- Back-to-back: hold `progValid`=1 and send 6'h3F then 6'h00. The second start bit falls 1 cycle after the first stop bit ends. The second frame's data is all zeros.
- Mid-frame changes: change `progNum` and pulse `progValid` during DATA. The transmitted bits match the originally latched word and no extra frame is started.
- Reset mid-frame: assert `rst_n`=0 during the 3rd data bit. `progOut`=1 within the same cycle (async). After release, the line stays idle until a new `progValid`.
